// File: rtl/e_viterbi_213.sv
// e_viterbi_213: hard-decision Viterbi decoder for the K=3 rate-1/2 (111,101) code,
// 4-state ACS with register-exchange survivors and a channel-error flag.
module e_viterbi_213 #(
    parameter int TB_DEPTH = 16,
    parameter int PM_W     = 4,
    parameter int PM_INIT  = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] Rx,
    input  logic       tb_en,
    output logic       Dx,
    output logic       Dx_oe,
    output logic       error
);
    localparam int CW = PM_W + 1;
    localparam int NW = $clog2(TB_DEPTH);
    localparam logic [NW-1:0] FULL = NW'(TB_DEPTH - 1);
    localparam logic [CW-1:0] SAT = CW'((1 << PM_W) - 1);

    logic [PM_W-1:0]     pm    [4];
    logic [PM_W-1:0]     pm_nx [4];
    logic [TB_DEPTH-1:0] sr    [4];
    logic [TB_DEPTH-1:0] sr_nx [4];
    logic [TB_DEPTH-1:0] surv  [4];
    logic [1:0]          p0    [4];
    logic [1:0]          p1    [4];
    logic [CW-1:0]       c0    [4];
    logic [CW-1:0]       c1    [4];
    logic [CW-1:0]       cand  [4];
    logic [CW-1:0]       norm  [4];
    logic [CW-1:0]       min_m;
    logic [1:0]          best;
    logic [NW-1:0]       cnt;

    function automatic logic [1:0] bm(input logic [1:0] s, input logic u, input logic [1:0] rx);
        logic [1:0] d;
        d = rx ^ {u ^ s[1] ^ s[0], u ^ s[0]};
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    // Next state {u,a} is reached from {a,0} or {a,1}; ties keep the {a,0} predecessor.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            p0[n]    = {n[0], 1'b0};
            p1[n]    = {n[0], 1'b1};
            c0[n]    = CW'(pm[p0[n]]) + CW'(bm(p0[n], n[1], Rx));
            c1[n]    = CW'(pm[p1[n]]) + CW'(bm(p1[n], n[1], Rx));
            cand[n]  = c1[n] < c0[n] ? c1[n] : c0[n];
            surv[n]  = c1[n] < c0[n] ? sr[p1[n]] : sr[p0[n]];
            sr_nx[n] = {surv[n][TB_DEPTH-2:0], n[1]};
        end
        min_m = cand[0];
        best  = 2'd0;
        for (int n = 1; n < 4; n++)
            if (cand[n] < min_m) begin
                min_m = cand[n];
                best  = 2'(n);
            end
        for (int n = 0; n < 4; n++) begin
            norm[n]  = cand[n] - min_m;
            pm_nx[n] = norm[n] > SAT ? {PM_W{1'b1}} : norm[n][PM_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pm    <= '{PM_W'(0), PM_W'(PM_INIT), PM_W'(PM_INIT), PM_W'(PM_INIT)};
            sr    <= '{default: '0};
            cnt   <= '0;
            Dx    <= 1'b0;
            Dx_oe <= 1'b0;
            error <= 1'b0;
        end else begin
            Dx_oe <= tb_en && cnt == FULL;
            error <= tb_en && min_m != '0;
            if (tb_en) begin
                pm  <= pm_nx;
                sr  <= sr_nx;
                Dx  <= sr_nx[best][TB_DEPTH-1];
                cnt <= cnt == FULL ? cnt : cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_e_viterbi_213.sv
// tb_e_viterbi_213: random and directed streams through a reference convolutional
// encoder; decoded bits are expected to equal the sent bits delayed by TB_DEPTH symbols.
module tb_e_viterbi_213;
    localparam int TB_DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tb_en = 1'b0;
    logic [1:0] Rx = 2'b00;
    logic       Dx, Dx_oe, error;

    int   n_checks = 0;
    int   n_fail = 0;
    logic [1:0] enc_st;
    logic sent[$];
    int   acc, last_err, oe_cnt;
    logic dx_exp;

    logic [1:0] t2_rx [6] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic       t2_u  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    e_viterbi_213 #(.TB_DEPTH(TB_DEPTH), .PM_W(4), .PM_INIT(7)) dut (
        .clock(clock), .reset(reset), .Rx(Rx), .tb_en(tb_en),
        .Dx(Dx), .Dx_oe(Dx_oe), .error(error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        enc_st = 2'b00;
        sent.delete();
        acc = 0;
        last_err = -1000;
        oe_cnt = 0;
        dx_exp = 1'b0;
    endtask

    // Drive one cycle; is_err marks a channel-corrupted pair on an accepted symbol.
    task automatic apply(input logic [1:0] pair, input logic u, input logic en, input logic is_err);
        @(negedge clock);
        Rx = pair;
        tb_en = en;
        @(posedge clock);
        #1;
        if (en) begin
            sent.push_back(u);
            acc++;
            if (acc >= TB_DEPTH) dx_exp = sent[acc - TB_DEPTH];
            if (Dx_oe) oe_cnt++;
            check("dx_oe", int'(Dx_oe), int'(acc >= TB_DEPTH));
            if (acc - 1 - last_err > 20) check(is_err ? "err_hit" : "err_quiet", int'(error), int'(is_err));
            if (is_err) last_err = acc - 1;
        end else begin
            check("oe_idle", int'(Dx_oe), 0);
            check("err_idle", int'(error), 0);
        end
        check("dx", int'(Dx), int'(dx_exp));
    endtask

    task automatic enc_send(input logic u, input logic en, input logic [1:0] flip);
        logic [1:0] pair;
        pair = {u ^ enc_st[1] ^ enc_st[0], u ^ enc_st[0]} ^ flip;
        apply(pair, u, en, en && flip != 2'b00);
        if (en) enc_st = {u, enc_st[1]};
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_dx", int'(Dx), 0);
        check("rst_oe", int'(Dx_oe), 0);
        check("rst_err", int'(error), 0);
        @(negedge clock);
        tb_en = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic       en, u, burst;
        logic [1:0] flip;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("init_dx", int'(Dx), 0);
        check("init_oe", int'(Dx_oe), 0);
        check("init_err", int'(error), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 40; i++) enc_send(1'b0, 1'b1, 2'b00);

        pulse_reset();
        for (int i = 0; i < 6; i++) apply(t2_rx[i], t2_u[i], 1'b1, 1'b0);
        enc_st = 2'b00;
        for (int i = 0; i < 20; i++) enc_send(1'b0, 1'b1, 2'b00);

        pulse_reset();
        for (int i = 0; i < 6; i++) apply(t2_rx[i] ^ (i == 2 ? 2'b10 : 2'b00), t2_u[i], 1'b1, i == 2);
        enc_st = 2'b00;
        for (int i = 0; i < 20; i++) enc_send(1'b0, 1'b1, 2'b00);

        pulse_reset();
        for (int i = 0; i < 30; i++) enc_send(1'b0, 1'b1, 2'b00);
        enc_send(1'b0, 1'b1, 2'b01);
        enc_send(1'b0, 1'b1, 2'b10);
        for (int i = 0; i < 40; i++) enc_send(1'b0, 1'b1, 2'b00);

        pulse_reset();
        burst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            en = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            flip = 2'b00;
            if (en && burst) begin
                flip = 2'($urandom_range(1, 2));
                burst = 1'b0;
            end else if (en && acc > 30 && acc - last_err > 60 && $urandom_range(0, 19) == 0) begin
                flip = 2'($urandom_range(1, 2));
                burst = 1'($urandom_range(0, 1));
            end
            enc_send(u, en, flip);
            if (i == 1000) begin
                pulse_reset();
                burst = 1'b0;
            end
        end
        check("oe_count", oe_cnt, acc >= TB_DEPTH ? acc - (TB_DEPTH - 1) : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
